// File: rtl/sram.sv
// -----------------------------------------------------------------------------
// sram: single-port 2**ADDR_WIDTH x DATA_WIDTH static RAM on a shared
// tri-state data bus.
//
// Ports
//   clk      rising-edge clock for all state
//   rst_n    asynchronous active-low reset; clears every word and rd_q
//   IOports  shared bus: write data in (CS=1,RWS=1), read data out (CS=1,RWS=0)
//   RWS      1 = write cycle, 0 = read cycle
//   CS       chip select, active high; 0 = idle, bus released
//   addr     word address
//
// Reads are registered (1-clock latency) into rd_q. rd_q is put on the bus
// whenever the block is selected for reading, so the bus shows the stale
// rd_q between selection and the first edge.
// -----------------------------------------------------------------------------
module sram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inout  wire  [DATA_WIDTH-1:0] IOports,
  input  logic                  RWS,
  input  logic                  CS,
  input  logic [ADDR_WIDTH-1:0] addr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  wr_en;
  logic                  rd_en;

  assign wr_en = CS &  RWS;
  assign rd_en = CS & ~RWS;

  // Storage lives in flops so the whole array can be cleared by reset.
  // Reset wins over a write in the same cycle by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[addr] <= IOports;
    end
  end

  // Read register: only loads on a selected read, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_q <= '0;
    else if (rd_en) rd_q <= mem[addr];
  end

  // Drive enable is combinational so the bus is released in the same delta
  // that RWS rises or CS falls; the master can start driving without contention.
  assign IOports = rd_en ? rd_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram.sv
// -----------------------------------------------------------------------------
// tb_sram: self-checking bench for sram. A plain array models the memory
// contents; expected bus values come from that array and the read rules.
// -----------------------------------------------------------------------------
module tb_sram;

  logic       clk;
  logic       rst_n;
  logic       RWS;
  logic       CS;
  logic [9:0] addr;
  logic [7:0] drv;
  logic       drv_en;
  wire  [7:0] bus;

  int errors = 0;
  int checks = 0;

  logic [7:0] model [0:1023];
  logic [7:0] last_rd;   // what the read register should hold

  assign bus = drv_en ? drv : 8'bzzzz_zzzz;

  sram #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .IOports (bus),
    .RWS     (RWS),
    .CS      (CS),
    .addr    (addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) model[i] = 8'h00;
    last_rd = 8'h00;
  endtask

  // Apply one cycle's inputs at the falling edge.
  task automatic drive(input logic cs, input logic rws, input logic [9:0] a,
                       input logic den, input logic [7:0] d);
    @(negedge clk);
    CS = cs; RWS = rws; addr = a; drv_en = den; drv = d;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [7:0] d);
    drive(1'b1, 1'b1, a, 1'b1, d);
    @(posedge clk); #1;
    model[a] = d;
  endtask

  // Present a read address, let one edge pass, return the bus just after it.
  task automatic do_read(input logic [9:0] a, output logic [7:0] v);
    drive(1'b1, 1'b0, a, 1'b0, 8'h00);
    @(posedge clk); #1;
    v = bus;
    last_rd = model[a];
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 1'b0; CS = 1'b0; RWS = 1'b0; addr = '0; drv_en = 1'b0; drv = '0;
    model_clear();
    #2;
    CS = 1'b1; RWS = 1'b0; #1;
    checks++;
    if (bus !== 8'h00) begin
      errors++; $display("FAIL reset_bus_drive: got %h want 00", bus);
    end
    CS = 1'b0; drv_en = 1'b1; drv = 8'hA5; #1;
    checks++;
    if (bus !== 8'hA5) begin
      errors++; $display("FAIL reset_idle_release: got %h want a5", bus);
    end
    @(negedge clk); rst_n = 1'b1; drv_en = 1'b0;
    do_read(10'd10, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL reset_read10: got %h want 00", v);
    end
  endtask

  task automatic test_idle_no_write();
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 10'd10, 1'b1, 8'd100);
      #1;
      checks++;
      if (bus !== 8'd100) begin
        errors++; $display("FAIL idle_bus_release: got %h want 64", bus);
      end
    end
    do_read(10'd10, v);
    checks++;
    if (v !== model[10]) begin
      errors++; $display("FAIL idle_no_write: got %h want %h", v, model[10]);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] v;
    do_write(10'd20, 8'd100);
    do_write(10'd20, 8'd200);
    do_write(10'd1000, 8'd1);
    do_read(10'd20, v);
    checks++;
    if (v !== 8'd200) begin
      errors++; $display("FAIL wr_rd_20: got %0d want 200", v);
    end
    do_read(10'd1000, v);
    checks++;
    if (v !== 8'd1) begin
      errors++; $display("FAIL wr_rd_1000: got %0d want 1", v);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0]  v;
    logic [9:0]  a [4];
    logic [7:0]  e [4];
    do_write(10'd0, 8'hA5);
    do_write(10'd1023, 8'h5A);
    a[0] = 10'd0;    e[0] = 8'hA5;
    a[1] = 10'd1023; e[1] = 8'h5A;
    a[2] = 10'd1;    e[2] = 8'h00;
    a[3] = 10'd1022; e[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      do_read(a[i], v);
      checks++;
      if (v !== e[i]) begin
        errors++; $display("FAIL boundary_addr%0d: got %h want %h", a[i], v, e[i]);
      end
    end
  endtask

  task automatic test_bus_turnaround();
    logic [7:0] v;
    do_read(10'd20, v);
    checks++;
    if (v !== 8'd200) begin
      errors++; $display("FAIL turn_read20: got %0d want 200", v);
    end
    // Flip to write while still selected; master drives in the same instant.
    @(negedge clk);
    RWS = 1'b1; drv_en = 1'b1; drv = 8'h33;
    #1;
    checks++;
    if (bus !== 8'h33) begin
      errors++; $display("FAIL turn_release: got %h want 33", bus);
    end
    @(posedge clk); #1;
    model[20] = 8'h33;
    do_read(10'd20, v);
    checks++;
    if (v !== 8'h33) begin
      errors++; $display("FAIL turn_written: got %h want 33", v);
    end
  endtask

  task automatic test_stale_rd();
    logic [7:0] v;
    logic [7:0] held;
    do_read(10'd1000, v);
    held = last_rd;
    drive(1'b0, 1'b0, 10'd0, 1'b1, 8'h96);
    @(posedge clk); #1;
    checks++;
    if (bus !== 8'h96) begin
      errors++; $display("FAIL stale_idle_release: got %h want 96", bus);
    end
    drive(1'b1, 1'b0, 10'd0, 1'b0, 8'h00);
    #1;
    checks++;
    if (bus !== held) begin
      errors++; $display("FAIL stale_before_edge: got %h want %h", bus, held);
    end
    @(posedge clk); #1;
    checks++;
    if (bus !== model[0]) begin
      errors++; $display("FAIL stale_after_edge: got %h want %h", bus, model[0]);
    end
    last_rd = model[0];
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) do_write(10'(100 + i), 8'(8'h10 * i + 3));
    for (int i = 0; i < 8; i++) begin
      do_read(10'(100 + i), v);
      checks++;
      if (v !== model[100 + i]) begin
        errors++; $display("FAIL b2b_read%0d: got %h want %h", 100 + i, v, model[100 + i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic [9:0] a;
    logic [7:0] d;
    int         op;
    for (int n = 0; n < 300; n++) begin
      a  = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 15))
                                       : 10'($urandom_range(0, 1023));
      d  = 8'($urandom);
      op = $urandom_range(0, 2);
      if (op == 0) begin
        do_write(a, d);
      end else if (op == 1) begin
        do_read(a, v);
        checks++;
        if (v !== model[a]) begin
          errors++; $display("FAIL rand_read n=%0d addr=%0d: got %h want %h", n, a, v, model[a]);
        end
      end else begin
        drive(1'b0, 1'($urandom_range(0, 1)), a, 1'b1, d);
        @(posedge clk); #1;
        checks++;
        if (bus !== d) begin
          errors++; $display("FAIL rand_idle n=%0d: got %h want %h", n, bus, d);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] v;
    do_write(10'd5, 8'h77);
    do_read(10'd5, v);
    checks++;
    if (v !== 8'h77) begin
      errors++; $display("FAIL rst_mid_pre: got %h want 77", v);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus !== 8'h00) begin
      errors++; $display("FAIL rst_mid_bus: got %h want 00", bus);
    end
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    do_read(10'd5, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL rst_mid_addr5: got %h want 00", v);
    end
    do_read(10'd1023, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL rst_mid_addr1023: got %h want 00", v);
    end
  endtask

  initial begin
    test_reset();
    test_idle_no_write();
    test_write_read();
    test_boundaries();
    test_bus_turnaround();
    test_stale_rd();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
